riscv_trace_buffer: RTL and testbench
=====================================

// Module: riscv_trace_buffer
// PURPOSE
//  Parametrised commit/memory trace capture for the riscv pipeline top.
//  Samples the core's debug taps every cycle: reg_write_sig/reg_num/reg_data and wr/rd/addr/wr_data/rd_data.
//  Packs enabled events into one timestamped record per cycle and queues it in a DEPTH-entry FIFO.
//  Drains over a valid/ready port to a testbench, UART or debug host.
//  Two full-policy modes; saturating loss counter.
// PARAMETERS
//  DATA_W   32   register/memory data width
//  ADDR_W   9    data-memory address width
//  DEPTH    16   FIFO entries; power of two, >=2
//  TS_W     16   timestamp counter width
// PORTS
//  clk           in   1                global clock, rising edge
//  reset         in   1                synchronous, active-high
//  reg_write_sig in   1                register-file write this cycle
//  reg_num       in   5                destination register
//  reg_data      in   DATA_W           write-back data
//  wr            in   1                data-memory store this cycle
//  rd            in   1                data-memory load this cycle
//  addr          in   ADDR_W           data-memory address
//  wr_data       in   DATA_W           store data
//  rd_data       in   DATA_W           load data
//  cfg_en_reg    in   1                capture register writes
//  cfg_en_mem    in   1                capture memory accesses
//  cfg_mode      in   1                0=drop-newest when full, 1=overwrite-oldest
//  trc_valid     out  1                head record available
//  trc_ready     in   1                consumer accepts head
//  trc_rec       out  trace_rec_t      head record (see package)
//  level         out  $clog2(DEPTH)+1  entries held
//  drop_cnt      out  16               records lost, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset:
//    - Pointers, level, drop_cnt and timestamp go to 0.
//    - trc_valid=0 and trc_rec='0 in the cycle after reset is sampled high.
//    - A reset mid-drain discards all queued records.
//  - Timestamp: TS_W free-running counter, +1 per cycle, wraps 2^TS_W-1 -> 0.
//    - Unaffected by capture enables.
//  - Event flags:
//    - ev_reg = reg_write_sig & cfg_en_reg & (reg_num!=0).
//    - ev_st = wr & cfg_en_mem.
//    - ev_ld = rd & cfg_en_mem.
//    - push = ev_reg | ev_st | ev_ld.
//  - Record contents:
//    - ts = current timestamp.
//    - kind = {ev_ld, ev_st, ev_reg}.
//    - rnum/rdata = inputs when ev_reg, else 0.
//    - maddr = addr when ev_st|ev_ld, else 0.
//    - mdata = wr_data if ev_st, else rd_data if ev_ld, else 0.
//  - Write latency: the record is visible at the head no earlier than 1 cycle after sampling.
//    - Into an empty FIFO, trc_valid rises exactly 1 cycle after the push cycle.
//  - Drain:
//    - Show-ahead; pop = trc_valid & trc_ready.
//    - While trc_valid=1 and trc_ready=0, trc_rec holds stable.
//    - Only exception: mode-1 overwrite, below.
//  - Occupancy: level = writes - reads; trc_valid = (level!=0).
//  - Push and pop in the same cycle, not full: both occur; level unchanged.
//  - Full (level==DEPTH) with push and pop in the same cycle: both occur in either mode; no loss.
//  - Full with push and no pop:
//    - mode 0: new record discarded; drop_cnt+1.
//    - mode 1: oldest entry discarded (read ptr advances); new record written; drop_cnt+1.
//      trc_rec may change while trc_valid stays 1.
//  - Empty with pop: impossible (trc_valid=0); no state change.
//  - drop_cnt: saturating, never wraps; cleared only by reset.
//  - cfg_* changes take effect in the same cycle they are sampled; queued records are unaffected.
//  - Pointers are $clog2(DEPTH)+1 bits; full/empty by MSB compare; wrap is natural.
// STRUCTURE
//  - Package riscv_trace_pkg:
//    - trace_rec_t packed struct {ts, kind[2:0], rnum[4:0], rdata, maddr, mdata}, parametrised via package localparams.
//    - KIND_REG/KIND_ST/KIND_LD bit constants.
//  - Sub-module riscv_trace_fifo: generic sync FIFO.
//    - Show-ahead, overwrite_en input, level output.
//  - Top holds event packing, the timestamp counter and drop_cnt.
// TESTING
//  1. Reset then idle: trc_valid=0, level=0, drop_cnt=0; cfg_en_reg=1, reg_write_sig=1 with reg_num=0 -> no push.
//  2. reg_write x5 (r5<=32'hDEAD_BEEF) at ts=3 with trc_ready=0 -> next cycle trc_valid=1,
//     trc_rec={ts=3, kind=3'b001, rnum=5, rdata=32'hDEADBEEF}, held stable 4 cycles.
//  3. Same-cycle store addr=9'h040, wr_data=7, plus reg write x1=1 -> one record, kind=3'b011, maddr=9'h040, mdata=7.
//  4. mode 0, trc_ready=0, 20 pushes into DEPTH=16 -> level=16, drop_cnt=4, drained ts values are the first 16.
//  5. mode 1, same stimulus -> level=16, drop_cnt=4, drained ts values are the last 16;
//     at full, push+pop same cycle -> drop_cnt unchanged.
//  6. Reset asserted with level=7 mid-drain -> next cycle level=0, trc_valid=0, timestamp=0.

Source files
------------

// File: rtl/riscv_trace_pkg.sv
// Shared types for the riscv trace capture path: record layout and event-kind masks.
package riscv_trace_pkg;

  localparam int TRC_DATA_W = 32;
  localparam int TRC_ADDR_W = 9;
  localparam int TRC_TS_W   = 16;

  localparam logic [2:0] KIND_REG = 3'b001;
  localparam logic [2:0] KIND_ST  = 3'b010;
  localparam logic [2:0] KIND_LD  = 3'b100;

  typedef struct packed {
    logic [TRC_TS_W-1:0]   ts;
    logic [2:0]            kind;
    logic [4:0]            rnum;
    logic [TRC_DATA_W-1:0] rdata;
    logic [TRC_ADDR_W-1:0] maddr;
    logic [TRC_DATA_W-1:0] mdata;
  } trace_rec_t;

endpackage

// File: rtl/riscv_trace_fifo.sv
// Generic show-ahead synchronous FIFO with optional overwrite-oldest on full.
module riscv_trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  input  logic                     overwrite_en,
  output logic [W-1:0]             rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     lost
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         empty, full, do_pop, do_push, evict;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO with no pop either evicts the head or is lost.
  assign lost    = push & full & ~do_pop;
  assign evict   = lost & overwrite_en;
  assign do_push = push & (~full | do_pop | overwrite_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop | evict) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign valid = ~empty;
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/riscv_trace_buffer.sv
// Commit/memory trace capture: packs core debug taps into timestamped records and queues them.
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int DATA_W = TRC_DATA_W,
  parameter int ADDR_W = TRC_ADDR_W,
  parameter int DEPTH  = 16,
  parameter int TS_W   = TRC_TS_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reg_write_sig,
  input  logic [4:0]             reg_num,
  input  logic [DATA_W-1:0]      reg_data,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W-1:0]      rd_data,
  input  logic                   cfg_en_reg,
  input  logic                   cfg_en_mem,
  input  logic                   cfg_mode,
  output logic                   trc_valid,
  input  logic                   trc_ready,
  output trace_rec_t             trc_rec,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            drop_cnt
);

  logic [TS_W-1:0] ts;
  logic            ev_reg, ev_st, ev_ld, push, lost;
  trace_rec_t      rec;

  assign ev_reg = reg_write_sig & cfg_en_reg & (reg_num != 5'd0);
  assign ev_st  = wr & cfg_en_mem;
  assign ev_ld  = rd & cfg_en_mem;
  assign push   = ev_reg | ev_st | ev_ld;

  always_comb begin
    rec      = '0;
    rec.ts   = ts;
    rec.kind = {ev_ld, ev_st, ev_reg};
    if (ev_reg) begin
      rec.rnum  = reg_num;
      rec.rdata = reg_data;
    end
    if (ev_st | ev_ld) rec.maddr = addr;
    // A simultaneous load and store reports the store data.
    if (ev_st)      rec.mdata = wr_data;
    else if (ev_ld) rec.mdata = rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts       <= '0;
      drop_cnt <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (lost && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  riscv_trace_fifo #(
    .W     ($bits(trace_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .wdata        (rec),
    .pop          (trc_ready),
    .overwrite_en (cfg_mode),
    .rdata        (trc_rec),
    .valid        (trc_valid),
    .level        (level),
    .lost         (lost)
  );

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Bench for riscv_trace_buffer: directed scenarios plus random traffic against a queue model.
module tb_riscv_trace_buffer;
  import riscv_trace_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_write_sig = 1'b0;
  logic [4:0]  reg_num = '0;
  logic [31:0] reg_data = '0;
  logic        wr = 1'b0, rd = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wr_data = '0, rd_data = '0;
  logic        cfg_en_reg = 1'b1, cfg_en_mem = 1'b1, cfg_mode = 1'b0;
  logic        trc_valid;
  logic        trc_ready = 1'b0;
  trace_rec_t  trc_rec;
  logic [4:0]  level;
  logic [15:0] drop_cnt;

  riscv_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .reg_write_sig(reg_write_sig), .reg_num(reg_num),
    .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .cfg_en_reg(cfg_en_reg), .cfg_en_mem(cfg_en_mem),
    .cfg_mode(cfg_mode), .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_rec(trc_rec), .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  trace_rec_t  q[$];
  int unsigned ts_m = 0;
  int unsigned drop_m = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update the reference queue from the applied inputs, then compare.
  task automatic tick();
    trace_rec_t r;
    logic er, es, el, do_push, do_pop, was_full;
    trace_rec_t exp_head;
    if (reset) begin
      q.delete();
      ts_m   = 0;
      drop_m = 0;
    end else begin
      er = reg_write_sig && cfg_en_reg && (reg_num != 5'd0);
      es = wr && cfg_en_mem;
      el = rd && cfg_en_mem;
      do_push = er | es | el;
      r = '0;
      r.ts   = ts_m[15:0];
      r.kind = {el, es, er};
      if (er) begin
        r.rnum  = reg_num;
        r.rdata = reg_data;
      end
      if (es | el) r.maddr = addr;
      if (es) r.mdata = wr_data;
      else if (el) r.mdata = rd_data;
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() != 0) && trc_ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        if (was_full && !do_pop) begin
          if (drop_m < 65535) drop_m++;
          if (cfg_mode) begin
            void'(q.pop_front());
            q.push_back(r);
          end
        end else begin
          q.push_back(r);
        end
      end
      ts_m = (ts_m + 1) % 65536;
    end
    @(posedge clk);
    #1;
    exp_head = (q.size() != 0) ? q[0] : '0;
    chk("trc_valid", trc_valid, q.size() != 0);
    chk("level", level, q.size());
    chk("drop_cnt", drop_cnt, drop_m);
    chk("trc_rec", trc_rec, exp_head);
  endtask

  task automatic idle_inputs();
    reg_write_sig = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_reg(input logic [4:0] n, input logic [31:0] d);
    reg_write_sig = 1'b1;
    reg_num  = n;
    reg_data = d;
    tick();
    reg_write_sig = 1'b0;
  endtask

  // Drains the queue, checking the k-th drained timestamp against first_ts + k.
  task automatic drain_check(input string tag, input int first_ts, input int count);
    int k = 0;
    idle_inputs();
    trc_ready = 1'b1;
    while (trc_valid && k < 64) begin
      chk(tag, trc_rec.ts, first_ts + k);
      tick();
      k++;
    end
    chk({tag, "_count"}, k, count);
    trc_ready = 1'b0;
  endtask

  trace_rec_t held;

  initial begin
    // Reset, then a write to x0 must not be captured.
    do_reset();
    chk("rst_valid", trc_valid, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_drop", drop_cnt, 0);
    push_reg(5'd0, 32'h1234_5678);
    chk("x0_no_push", level, 0);
    tick();
    tick();

    // x5 <= DEADBEEF at ts=3, held while not ready.
    push_reg(5'd5, 32'hDEAD_BEEF);
    chk("t2_valid", trc_valid, 1'b1);
    chk("t2_ts", trc_rec.ts, 3);
    chk("t2_kind", trc_rec.kind, 3'b001);
    chk("t2_rnum", trc_rec.rnum, 5);
    chk("t2_rdata", trc_rec.rdata, 32'hDEAD_BEEF);
    held = trc_rec;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_hold", trc_rec, held);
    end

    // Same-cycle store and register write share one record.
    reg_write_sig = 1'b1; reg_num = 5'd1; reg_data = 32'd1;
    wr = 1'b1; addr = 9'h040; wr_data = 32'd7;
    tick();
    idle_inputs();
    chk("t3_level", level, 2);
    trc_ready = 1'b1;
    tick();
    trc_ready = 1'b0;
    chk("t3_kind", trc_rec.kind, 3'b011);
    chk("t3_maddr", trc_rec.maddr, 9'h040);
    chk("t3_mdata", trc_rec.mdata, 32'd7);
    chk("t3_rnum", trc_rec.rnum, 1);
    chk("t3_ts", trc_rec.ts, 8);
    drain_check("t3_drain", 8, 1);

    // Drop-newest: 20 pushes at ts 0..19 keep ts 0..15.
    cfg_mode = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) push_reg(5'd3, 32'(i));
    chk("t4_level", level, 16);
    chk("t4_drop", drop_cnt, 4);
    drain_check("t4_ts", 0, 16);

    // Overwrite-oldest: keeps ts 4..19; then push+pop at full loses nothing.
    cfg_mode = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) push_reg(5'd4, 32'(i));
    chk("t5_level", level, 16);
    chk("t5_drop", drop_cnt, 4);
    chk("t5_head", trc_rec.ts, 4);
    trc_ready = 1'b1;
    push_reg(5'd4, 32'd99);
    trc_ready = 1'b0;
    chk("t5_pp_drop", drop_cnt, 4);
    chk("t5_pp_level", level, 16);
    drain_check("t5_ts", 5, 16);

    // Reset mid-drain discards everything and restarts the timestamp.
    cfg_mode = 1'b0;
    for (int i = 0; i < 8; i++) push_reg(5'd6, 32'(i));
    trc_ready = 1'b1;
    tick();
    chk("t6_level_pre", level, 7);
    do_reset();
    chk("t6_level", level, 0);
    chk("t6_valid", trc_valid, 1'b0);
    trc_ready = 1'b0;
    push_reg(5'd7, 32'hA5A5_A5A5);
    chk("t6_ts", trc_rec.ts, 0);

    // Random traffic against the queue model.
    for (int seg = 0; seg < 15; seg++) begin
      int rdy_pct = $urandom_range(5, 95);
      cfg_mode   = 1'($urandom_range(0, 1));
      cfg_en_reg = ($urandom_range(0, 9) != 0);
      cfg_en_mem = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < 200; c++) begin
        reset         = ($urandom_range(0, 499) == 0);
        reg_write_sig = 1'($urandom_range(0, 1));
        reg_num       = 5'($urandom_range(0, 31));
        reg_data      = $urandom;
        wr            = ($urandom_range(0, 3) == 0);
        rd            = ($urandom_range(0, 3) == 0);
        addr          = 9'($urandom);
        wr_data       = $urandom;
        rd_data       = $urandom;
        trc_ready     = ($urandom_range(0, 99) < rdy_pct);
        if ($urandom_range(0, 49) == 0) cfg_mode = ~cfg_mode;
        tick();
      end
    end
    reset = 1'b0;
    cfg_en_reg = 1'b1;
    cfg_en_mem = 1'b1;
    idle_inputs();
    trc_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("final_empty", trc_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
